guess_round_ctrl: RTL and testbench

GUESS_ROUND_CTRL -- requirements
Module: guess_round_ctrl

---
 rtl/guess_pkg.sv | 21 ++
 rtl/guess_timer.sv | 27 ++
 rtl/guess_round_ctrl.sv | 174 +++++++++++++++++
 tb/tb_guess_round_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/guess_pkg.sv
// Shared state encoding and default parameters for the guessing-game round controller.
package guess_pkg;

  localparam int DEF_MAX_TRIES   = 7;
  localparam int DEF_TRIES_W     = 4;
  localparam int DEF_ROUNDS      = 3;
  localparam int DEF_ROUND_W     = 2;
  localparam int DEF_TIMEOUT_CYC = 0;

  typedef enum logic [2:0] {
    S_SEED,
    S_SEED_REL,
    S_COMPARE,
    S_WAIT,
    S_WAIT_REL,
    S_WIN,
    S_LOSE,
    S_END
  } state_t;

endpackage

// File: rtl/guess_timer.sv
// Idle-cycle counter for the guess wait state; expire marks the TIMEOUT_CYC-th enabled cycle.
module guess_timer #(
  parameter int TIMEOUT_CYC = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  // cnt holds the number of idle cycles already completed, so the last one sees TIMEOUT_CYC-1
  assign expire = enable && (cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/guess_round_ctrl.sv
// Round/game sequencer for the number-guessing game: seeds the target, paces guesses,
// tracks tries, rounds and wins, and reports per-round results.
//
// state      | meaning
// S_SEED     | target counter free-running until the player presses enter
// S_SEED_REL | waiting for enter release before the first compare
// S_COMPARE  | one-cycle compare: latch LEDs, judge the guess
// S_WAIT     | waiting for the next guess (optional idle timeout)
// S_WAIT_REL | waiting for enter release before the next compare
// S_WIN      | round won: count the win, then next round or game end
// S_LOSE     | round lost: next round or game end
// S_END      | game over; a press-release starts a new game
module guess_round_ctrl
  import guess_pkg::*;
#(
  parameter int MAX_TRIES   = DEF_MAX_TRIES,
  parameter int TRIES_W     = DEF_TRIES_W,
  parameter int ROUNDS      = DEF_ROUNDS,
  parameter int ROUND_W     = DEF_ROUND_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_enter,
  input  logic               i_over,
  input  logic               i_under,
  input  logic               i_equal,
  output logic               o_inc_actual,
  output logic               o_update_leds,
  output logic [TRIES_W-1:0] o_tries_left,
  output logic [ROUND_W-1:0] o_round,
  output logic [ROUND_W-1:0] o_wins,
  output logic               o_round_win,
  output logic               o_round_lose,
  output logic               o_done
);

  localparam logic [TRIES_W-1:0] TRIES_MAX  = TRIES_W'(MAX_TRIES);
  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(ROUNDS - 1);
  localparam logic [ROUND_W-1:0] WINS_MAX   = '1;

  state_t             state, state_nxt;
  logic [TRIES_W-1:0] tries, tries_nxt, tries_dec;
  logic [ROUND_W-1:0] round, round_nxt;
  logic [ROUND_W-1:0] wins, wins_nxt;
  logic               end_armed, end_armed_nxt;
  logic               expire;
  logic               inc, upd, win_p, lose_p, done;
  state_t             miss_state;

  // Over/under only drive the LEDs outside this block; the controller judges on equal alone.
  logic unused_flags;
  assign unused_flags = i_over ^ i_under;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_SEED;
      tries     <= TRIES_MAX;
      round     <= '0;
      wins      <= '0;
      end_armed <= 1'b0;
    end else begin
      state     <= state_nxt;
      tries     <= tries_nxt;
      round     <= round_nxt;
      wins      <= wins_nxt;
      end_armed <= end_armed_nxt;
    end
  end

  assign tries_dec  = (tries == '0) ? tries : tries - 1'b1;
  assign miss_state = (tries == TRIES_W'(1)) ? S_LOSE : S_WAIT;

  always_comb begin
    state_nxt     = state;
    tries_nxt     = tries;
    round_nxt     = round;
    wins_nxt      = wins;
    end_armed_nxt = end_armed;
    inc           = 1'b0;
    upd           = 1'b0;
    win_p         = 1'b0;
    lose_p        = 1'b0;
    done          = 1'b0;

    case (state)
      S_SEED: begin
        inc = 1'b1;
        if (i_enter) state_nxt = S_SEED_REL;
      end
      S_SEED_REL: begin
        if (!i_enter) state_nxt = S_COMPARE;
      end
      S_COMPARE: begin
        upd = 1'b1;
        if (i_equal) begin
          state_nxt = S_WIN;
        end else begin
          tries_nxt = tries_dec;
          state_nxt = miss_state;
        end
      end
      S_WAIT: begin
        // A press in the expiring cycle still counts as a real guess.
        if (i_enter) begin
          state_nxt = S_WAIT_REL;
        end else if (expire) begin
          upd       = 1'b1;
          tries_nxt = tries_dec;
          state_nxt = miss_state;
        end
      end
      S_WAIT_REL: begin
        if (!i_enter) state_nxt = S_COMPARE;
      end
      S_WIN, S_LOSE: begin
        win_p  = (state == S_WIN);
        lose_p = (state == S_LOSE);
        if (state == S_WIN && wins != WINS_MAX) wins_nxt = wins + 1'b1;
        if (round == LAST_ROUND) begin
          state_nxt = S_END;
        end else begin
          round_nxt = round + 1'b1;
          tries_nxt = TRIES_MAX;
          state_nxt = S_SEED;
        end
      end
      S_END: begin
        done = 1'b1;
        if (i_enter) begin
          end_armed_nxt = 1'b1;
        end else if (end_armed) begin
          end_armed_nxt = 1'b0;
          round_nxt     = '0;
          wins_nxt      = '0;
          tries_nxt     = TRIES_MAX;
          state_nxt     = S_SEED;
        end
      end
      default: begin
        state_nxt = S_SEED;
      end
    endcase
  end

  generate
    if (TIMEOUT_CYC > 0) begin : g_timer
      logic timer_clear;
      assign timer_clear = (state != S_WAIT) || expire;
      guess_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
      ) u_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (timer_clear),
        .enable (state == S_WAIT),
        .expire (expire)
      );
    end else begin : g_no_timer
      assign expire = 1'b0;
    end
  endgenerate

  // Strobes and status stay quiet while reset is held, whatever the state register holds.
  assign o_inc_actual  = inc && reset_n;
  assign o_update_leds = upd && reset_n;
  assign o_round_win   = win_p && reset_n;
  assign o_round_lose  = lose_p && reset_n;
  assign o_done        = done && reset_n;
  assign o_tries_left  = tries;
  assign o_round       = round;
  assign o_wins        = wins;

endmodule

// File: tb/tb_guess_round_ctrl.sv
// Bench for guess_round_ctrl: a cycle vector table, directed corner sequences and a
// randomized game checked against a guess-level model of the rules.
module tb_guess_round_ctrl;

  logic       clk = 1'b0;
  logic       rst_n [2] = '{1'b0, 1'b0};
  logic       enter [2] = '{1'b0, 1'b0};
  logic       over  [2] = '{1'b0, 1'b0};
  logic       under [2] = '{1'b0, 1'b0};
  logic       equal [2] = '{1'b0, 1'b0};
  logic       inc   [2];
  logic       upd   [2];
  logic       rwin  [2];
  logic       rlose [2];
  logic       done  [2];
  logic [3:0] tries [2];
  logic [1:0] rnd   [2];
  logic [1:0] wins  [2];

  int checks = 0;
  int errors = 0;

  int n_upd  [2] = '{0, 0};
  int n_win  [2] = '{0, 0};
  int n_lose [2] = '{0, 0};

  // game rules per instance: dut 0 defaults, dut 1 short game with idle timeout
  int MX [2] = '{7, 3};
  int RN [2] = '{3, 1};

  int m_tries [2], m_round [2], m_wins [2];
  bit m_done [2], m_seed [2];
  int e_upd [2], e_win [2], e_lose [2];

  guess_round_ctrl #(.TIMEOUT_CYC(0)) u_dut0 (
    .clk(clk), .reset_n(rst_n[0]), .i_enter(enter[0]), .i_over(over[0]),
    .i_under(under[0]), .i_equal(equal[0]), .o_inc_actual(inc[0]),
    .o_update_leds(upd[0]), .o_tries_left(tries[0]), .o_round(rnd[0]),
    .o_wins(wins[0]), .o_round_win(rwin[0]), .o_round_lose(rlose[0]), .o_done(done[0])
  );

  guess_round_ctrl #(.MAX_TRIES(3), .ROUNDS(1), .TIMEOUT_CYC(10)) u_dut1 (
    .clk(clk), .reset_n(rst_n[1]), .i_enter(enter[1]), .i_over(over[1]),
    .i_under(under[1]), .i_equal(equal[1]), .o_inc_actual(inc[1]),
    .o_update_leds(upd[1]), .o_tries_left(tries[1]), .o_round(rnd[1]),
    .o_wins(wins[1]), .o_round_win(rwin[1]), .o_round_lose(rlose[1]), .o_done(done[1])
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (upd[d] === 1'b1)   n_upd[d]  += 1;
      if (rwin[d] === 1'b1)  n_win[d]  += 1;
      if (rlose[d] === 1'b1) n_lose[d] += 1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset(input int d);
    m_tries[d] = MX[d];
    m_round[d] = 0;
    m_wins[d]  = 0;
    m_done[d]  = 1'b0;
    m_seed[d]  = 1'b1;
    e_upd[d]   = n_upd[d];
    e_win[d]   = n_win[d];
    e_lose[d]  = n_lose[d];
  endtask

  // one judged guess (a real compare or a timeout forfeit)
  task automatic model_guess(input int d, input bit eq);
    bit round_over = 1'b0;
    e_upd[d]++;
    m_seed[d] = 1'b0;
    if (eq) begin
      e_win[d]++;
      if (m_wins[d] < 3) m_wins[d]++;
      round_over = 1'b1;
    end else begin
      if (m_tries[d] == 1) begin
        e_lose[d]++;
        round_over = 1'b1;
      end
      if (m_tries[d] > 0) m_tries[d]--;
    end
    if (round_over) begin
      if (m_round[d] == RN[d] - 1) begin
        m_done[d] = 1'b1;
      end else begin
        m_round[d]++;
        m_tries[d] = MX[d];
        m_seed[d]  = 1'b1;
      end
    end
  endtask

  task automatic model_restart(input int d);
    m_round[d] = 0;
    m_wins[d]  = 0;
    m_tries[d] = MX[d];
    m_done[d]  = 1'b0;
    m_seed[d]  = 1'b1;
  endtask

  task automatic check_model(input int d, input string tag);
    chk({tag, ".tries"}, 32'(tries[d]), m_tries[d]);
    chk({tag, ".round"}, 32'(rnd[d]), m_round[d]);
    chk({tag, ".wins"},  32'(wins[d]), m_wins[d]);
    chk({tag, ".done"},  32'(done[d]), 32'(m_done[d]));
    chk({tag, ".inc"},   32'(inc[d]), 32'(m_seed[d] && !m_done[d]));
    chk({tag, ".n_upd"}, n_upd[d], e_upd[d]);
    chk({tag, ".n_win"}, n_win[d], e_win[d]);
    chk({tag, ".n_lose"}, n_lose[d], e_lose[d]);
  endtask

  task automatic do_reset(input int d);
    rst_n[d] = 1'b0;
    enter[d] = 1'b0;
    equal[d] = 1'b0;
    over[d]  = 1'b0;
    under[d] = 1'b0;
    tick();
    tick();
    chk("in_reset.inc",  32'(inc[d]), 0);
    chk("in_reset.done", 32'(done[d]), 0);
    chk("in_reset.upd",  32'(upd[d]), 0);
    rst_n[d] = 1'b1;
    #1;
    chk("after_release.inc", 32'(inc[d]), 1);
    model_reset(d);
  endtask

  // press for 'hold' cycles, release, let the block settle; then advance the model
  task automatic do_action(input int d, input int hold, input bit eq);
    equal[d] = eq;
    over[d]  = (!eq) && ($urandom_range(0, 1) == 1);
    under[d] = (!eq) && !over[d];
    enter[d] = 1'b1;
    repeat (hold) tick();
    enter[d] = 1'b0;
    repeat (3) tick();
    if (m_done[d]) model_restart(d);
    else           model_guess(d, eq);
  endtask

  typedef struct {
    int en, eq, inc, upd, win, lose, done, tries, rnd, wins;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int u0, w0, l0, exp_bits;
    logic [12:0] act_bits;

    //         en eq inc upd win lose done tries rnd wins
    vecs[0] = '{0, 0, 1,  0,  0,  0,   0,   7,    0,  0};
    vecs[1] = '{1, 0, 1,  0,  0,  0,   0,   7,    0,  0};
    vecs[2] = '{0, 0, 0,  0,  0,  0,   0,   7,    0,  0};
    vecs[3] = '{0, 0, 0,  1,  0,  0,   0,   7,    0,  0};
    vecs[4] = '{0, 0, 0,  0,  0,  0,   0,   6,    0,  0};
    vecs[5] = '{1, 0, 0,  0,  0,  0,   0,   6,    0,  0};
    vecs[6] = '{0, 1, 0,  0,  0,  0,   0,   6,    0,  0};
    vecs[7] = '{0, 1, 0,  1,  0,  0,   0,   6,    0,  0};
    vecs[8] = '{0, 0, 0,  0,  1,  0,   0,   6,    0,  0};
    vecs[9] = '{0, 0, 1,  0,  0,  0,   0,   7,    1,  1};

    // cycle table: seed, one miss, hit on the second guess
    do_reset(0);
    for (int i = 0; i < 10; i++) begin
      enter[0] = vecs[i].en[0];
      equal[0] = vecs[i].eq[0];
      #1;
      exp_bits = vecs[i].inc * 4096 + vecs[i].upd * 2048 + vecs[i].win * 1024 +
                 vecs[i].lose * 512 + vecs[i].done * 256 + vecs[i].tries * 16 +
                 vecs[i].rnd * 4 + vecs[i].wins;
      act_bits = {inc[0], upd[0], rwin[0], rlose[0], done[0], tries[0], rnd[0], wins[0]};
      chk($sformatf("vec[%0d]", i), 32'(act_bits), exp_bits);
      tick();
    end

    // enter held 20 cycles in the wait state: one compare, after release
    do_reset(0);
    do_action(0, 1, 1'b0);
    check_model(0, "hold.pre");
    u0 = n_upd[0];
    equal[0] = 1'b0;
    enter[0] = 1'b1;
    repeat (20) tick();
    chk("hold.no_upd_while_held", n_upd[0] - u0, 0);
    enter[0] = 1'b0;
    repeat (3) tick();
    chk("hold.one_upd", n_upd[0] - u0, 1);
    model_guess(0, 1'b0);
    check_model(0, "hold.post");

    // reset mid-round in the release wait with tries=2
    do_reset(0);
    do_action(0, 1, 1'b1);
    for (int i = 0; i < 5; i++) do_action(0, 1, 1'b0);
    check_model(0, "midrst.pre");
    chk("midrst.tries_is_2", 32'(tries[0]), 2);
    u0 = n_upd[0];
    w0 = n_win[0];
    l0 = n_lose[0];
    enter[0] = 1'b1;
    tick();
    tick();
    rst_n[0] = 1'b0;
    enter[0] = 1'b0;
    tick();
    rst_n[0] = 1'b1;
    #1;
    chk("midrst.tries", 32'(tries[0]), 7);
    chk("midrst.round", 32'(rnd[0]), 0);
    chk("midrst.wins",  32'(wins[0]), 0);
    chk("midrst.inc",   32'(inc[0]), 1);
    chk("midrst.no_upd",  n_upd[0] - u0, 0);
    chk("midrst.no_win",  n_win[0] - w0, 0);
    chk("midrst.no_lose", n_lose[0] - l0, 0);
    model_reset(0);

    // win every round, then restart from game over
    do_reset(0);
    for (int i = 0; i < 3; i++) begin
      do_action(0, 2, 1'b1);
      check_model(0, $sformatf("allwin[%0d]", i));
    end
    chk("allwin.wins", 32'(wins[0]), 3);
    chk("allwin.done", 32'(done[0]), 1);
    repeat (4) tick();
    chk("allwin.done_holds", 32'(done[0]), 1);
    do_action(0, 3, 1'b0);
    check_model(0, "restart");
    chk("restart.round", 32'(rnd[0]), 0);
    chk("restart.wins",  32'(wins[0]), 0);
    chk("restart.tries", 32'(tries[0]), 7);

    // randomized play against the rule model
    do_reset(0);
    for (int i = 0; i < 60; i++) begin
      do_action(0, int'($urandom_range(1, 4)), ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 3)) tick();
      check_model(0, $sformatf("rand[%0d]", i));
    end

    // short game: three misses lose the only round
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      do_action(1, 1, 1'b0);
      chk($sformatf("short.tries[%0d]", i), 32'(tries[1]), 2 - i);
      check_model(1, $sformatf("short[%0d]", i));
    end
    chk("short.done", 32'(done[1]), 1);
    chk("short.wins", 32'(wins[1]), 0);

    // idle timeout: forfeit on the 10th idle cycle, a press in that cycle prevents it
    do_reset(1);
    equal[1] = 1'b0;
    enter[1] = 1'b1;
    tick();
    enter[1] = 1'b0;
    tick();
    tick();
    model_guess(1, 1'b0);
    check_model(1, "to.wait");
    for (int k = 1; k < 10; k++) begin
      chk($sformatf("to.idle[%0d].upd", k), 32'(upd[1]), 0);
      tick();
    end
    chk("to.forfeit_upd", 32'(upd[1]), 1);
    tick();
    model_guess(1, 1'b0);
    check_model(1, "to.after_forfeit");
    chk("to.tries_after_forfeit", 32'(tries[1]), 1);
    repeat (9) tick();
    enter[1] = 1'b1;
    #1;
    chk("to.press_beats_forfeit", 32'(upd[1]), 0);
    tick();
    chk("to.tries_kept", 32'(tries[1]), 1);
    enter[1] = 1'b0;
    repeat (3) tick();
    model_guess(1, 1'b0);
    check_model(1, "to.final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
